// File: rtl/a5_pkg.sv
// Shared A5/1 definitions: controller state encoding, LFSR geometry,
// feedback tap masks, clocking tap positions and the majority helper.
package a5_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_FRAME,
        S_WARMUP,
        S_GEN,
        S_KS_READY
    } state_t;

    localparam int R1_W = 19;
    localparam int R2_W = 22;
    localparam int R3_W = 23;

    // Feedback taps as masks: R1 {5,2,1,0}, R2 {1,0}, R3 {15,2,1,0}.
    localparam logic [R1_W-1:0] R1_TAPS = 19'h00027;
    localparam logic [R2_W-1:0] R2_TAPS = 22'h000003;
    localparam logic [R3_W-1:0] R3_TAPS = 23'h008007;

    localparam int R1_CLK = 10;
    localparam int R2_CLK = 11;
    localparam int R3_CLK = 12;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a5_keystream_gen.sv
// A5/1 LFSR core. load_en steps all three registers with load_bit folded into
// every feedback; maj_en applies majority clocking. ks_bit is taken from the
// post-step register values so it can be captured in the stepping cycle.
module a5_keystream_gen
    import a5_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load_en,
    input  logic load_bit,
    input  logic maj_en,
    output logic ks_bit
);

    logic [R1_W-1:0] r1, r1_nxt;
    logic [R2_W-1:0] r2, r2_nxt;
    logic [R3_W-1:0] r3, r3_nxt;
    logic            maj;

    // Next register values: keyed load step, majority step, or hold.
    always_comb begin
        r1_nxt = r1;
        r2_nxt = r2;
        r3_nxt = r3;
        maj    = maj3(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);
        if (load_en) begin
            r1_nxt = {(^(r1 & R1_TAPS)) ^ load_bit, r1[R1_W-1:1]};
            r2_nxt = {(^(r2 & R2_TAPS)) ^ load_bit, r2[R2_W-1:1]};
            r3_nxt = {(^(r3 & R3_TAPS)) ^ load_bit, r3[R3_W-1:1]};
        end else if (maj_en) begin
            if (r1[R1_CLK] == maj) r1_nxt = {^(r1 & R1_TAPS), r1[R1_W-1:1]};
            if (r2[R2_CLK] == maj) r2_nxt = {^(r2 & R2_TAPS), r2[R2_W-1:1]};
            if (r3[R3_CLK] == maj) r3_nxt = {^(r3 & R3_TAPS), r3[R3_W-1:1]};
        end
    end

    assign ks_bit = r1_nxt[0] ^ r2_nxt[0] ^ r3_nxt[0];

    // LFSR state; clr zeroes all three at the start of every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else if (clr) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            r1 <= r1_nxt;
            r2 <= r2_nxt;
            r3 <= r3_nxt;
        end
    end

endmodule

// File: rtl/a5_stream_decipher.sv
// A5/1 streaming decipher: regenerates one keystream word just in time and
// XORs it onto each accepted ciphertext word.
// Optional macro A5_AUTO_FRAME_EN: at frame end, bump the frame number and
// restart key loading without a new start pulse.
//
// state        | meaning
// S_IDLE       | waiting for start
// S_LOAD_KEY   | clocking key bits MSB first into all LFSRs
// S_LOAD_FRAME | clocking frame bits MSB first into all LFSRs
// S_WARMUP     | majority-clocked discard cycles
// S_GEN        | majority clocking, one keystream bit per cycle into ksbuf
// S_KS_READY   | keystream word ready, waiting for ciphertext
module a5_stream_decipher
    import a5_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int KEY_W       = 64,
    parameter int FRAME_W     = 22,
    parameter int WARMUP      = 100,
    parameter int FRAME_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [KEY_W-1:0]   key,
    input  logic [FRAME_W-1:0] frame,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(DATA_W > WARMUP ? DATA_W : WARMUP);
    localparam int DI_W  = $clog2(DATA_W);
    localparam int KI_W  = $clog2(KEY_W);
    localparam int FI_W  = $clog2(FRAME_W);
    localparam int WC_W  = $clog2(FRAME_WORDS);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WC_W-1:0]    word_cnt;
    logic [KEY_W-1:0]   key_q;
    logic [FRAME_W-1:0] frame_q;
    logic [DATA_W-1:0]  ksbuf;
    logic               load_en, load_bit, maj_en, ks_bit;
    logic               accept, last_word, begin_frame, restart, ks_clr;

    // Phase lengths as down-counter preloads; the bit index equals the count.
    function automatic logic [CNT_W-1:0] cnt_init(input state_t s);
        case (s)
            S_LOAD_KEY:   cnt_init = CNT_W'(KEY_W - 1);
            S_LOAD_FRAME: cnt_init = CNT_W'(FRAME_W - 1);
            S_WARMUP:     cnt_init = CNT_W'(WARMUP - 1);
            S_GEN:        cnt_init = CNT_W'(DATA_W - 1);
            default:      cnt_init = '0;
        endcase
    endfunction

    a5_keystream_gen u_ksgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ks_clr),
        .load_en  (load_en),
        .load_bit (load_bit),
        .maj_en   (maj_en),
        .ks_bit   (ks_bit)
    );

    // Next-state and control decode; abort overrides everything, including start.
    always_comb begin
        state_nxt   = state;
        load_en     = 1'b0;
        load_bit    = 1'b0;
        maj_en      = 1'b0;
        s_ready     = 1'b0;
        accept      = 1'b0;
        last_word   = 1'b0;
        begin_frame = 1'b0;
        restart     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    begin_frame = 1'b1;
                    state_nxt   = S_LOAD_KEY;
                end
            end
            S_LOAD_KEY: begin
                load_en  = 1'b1;
                load_bit = key_q[cnt[KI_W-1:0]];
                if (cnt == '0) state_nxt = S_LOAD_FRAME;
            end
            S_LOAD_FRAME: begin
                load_en  = 1'b1;
                load_bit = frame_q[cnt[FI_W-1:0]];
                if (cnt == '0) state_nxt = S_WARMUP;
            end
            S_WARMUP: begin
                maj_en = 1'b1;
                if (cnt == '0) state_nxt = S_GEN;
            end
            S_GEN: begin
                maj_en = 1'b1;
                if (cnt == '0) state_nxt = S_KS_READY;
            end
            S_KS_READY: begin
                s_ready = !m_valid || m_ready;
                accept  = s_valid && s_ready;
                if (accept) begin
                    if (word_cnt == WC_W'(FRAME_WORDS - 1)) begin
                        last_word = 1'b1;
`ifdef A5_AUTO_FRAME_EN
                        restart   = 1'b1;
                        state_nxt = S_LOAD_KEY;
`else
                        state_nxt = S_IDLE;
`endif
                    end else begin
                        state_nxt = S_GEN;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt   = S_IDLE;
            load_en     = 1'b0;
            maj_en      = 1'b0;
            s_ready     = 1'b0;
            accept      = 1'b0;
            last_word   = 1'b0;
            begin_frame = 1'b0;
            restart     = 1'b0;
        end
    end

    assign ks_clr = begin_frame || restart;
    assign busy   = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Phase counter, session capture and word counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            key_q    <= '0;
            frame_q  <= '0;
            word_cnt <= '0;
        end else begin
            if (state_nxt != state) cnt <= cnt_init(state_nxt);
            else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
            if (begin_frame) begin
                key_q   <= key;
                frame_q <= frame;
            end
`ifdef A5_AUTO_FRAME_EN
            else if (restart) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
`endif
            if (ks_clr || last_word) word_cnt <= '0;
            else if (accept)         word_cnt <= word_cnt + WC_W'(1);
        end
    end

    // Keystream buffer fill and registered plaintext output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ksbuf      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (abort || ks_clr)  ksbuf <= '0;
            else if (state == S_GEN) ksbuf[cnt[DI_W-1:0]] <= ks_bit;
            if (accept) begin
                m_data  <= s_data ^ ksbuf;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            frame_done <= last_word;
        end
    end

endmodule
